// File: rtl/sb_tx_framer.sv
// Sideband transmit framer: DLE/STX/payload/CRC/DLE/ETX symbols, 10 line bits each.
// Optional SB_DLE_STUFF_EN: payload bytes equal to 0xFE are sent twice back-to-back.
module sb_tx_framer (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       parity,
  output logic       crc_en,
  output logic       crc_active,
  output logic       trans_ser,
  output logic       sb_tx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state,
  output logic [3:0] dbg_bit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DLE1    = 3'd1,
    S_STX     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CRC     = 3'd4,
    S_DLE2    = 3'd5,
    S_ETX     = 3'd6
  } state_t;

  localparam logic [7:0] DLE_B = 8'hFE;
  localparam logic [7:0] STX_B = 8'h05;
  localparam logic [7:0] ETX_B = 8'h40;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [9:0] shift_q;
  logic [3:0] rem_q;
  logic       crc_sym_q;
  logic       done_q;
  logic       err_q;
`ifdef SB_DLE_STUFF_EN
  logic [7:0] byte_q;
  logic       dup_q;
`endif

  logic bit9;
  logic last_pay;
  logic stuff_now;

  function automatic logic [9:0] sym(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  assign bit9     = (bit_cnt_q == 4'd9);
  assign last_pay = (rem_q == 4'd1);

`ifdef SB_DLE_STUFF_EN
  // First copy of a 0xFE byte: repeat it instead of asking for the next byte.
  assign stuff_now = (byte_q == DLE_B) && !dup_q;
`else
  assign stuff_now = 1'b0;
`endif

  // data_ready/data_valid: a byte transfers in a cycle where both are 1; the
  // framer only raises data_ready on bit9 and expects data_valid there, else aborts.
  assign data_ready = bit9 && ((state_q == S_STX) ||
                               ((state_q == S_PAYLOAD) && !last_pay && !stuff_now));

  assign busy        = (state_q != S_IDLE);
  assign crc_en      = (state_q == S_PAYLOAD) || (state_q == S_CRC);
  assign crc_active  = (state_q == S_CRC);
  assign trans_ser   = (state_q == S_PAYLOAD) ? shift_q[0] : 1'b0;
  assign sb_tx       = (state_q == S_CRC)  ? parity :
                       (state_q == S_IDLE) ? 1'b1   : shift_q[0];
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state   = state_q;
  assign dbg_bit_cnt = bit_cnt_q;

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= '1;
      rem_q     <= 4'd0;
      crc_sym_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SB_DLE_STUFF_EN
      byte_q    <= 8'd0;
      dup_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == S_IDLE) begin
        bit_cnt_q <= 4'd0;
        if (start && (len != 4'd0)) begin
          state_q <= S_DLE1;
          rem_q   <= len;
          shift_q <= sym(DLE_B);
        end
      end else if (!bit9) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
        shift_q   <= {1'b1, shift_q[9:1]};
      end else begin
        bit_cnt_q <= 4'd0;
        unique case (state_q)
          S_DLE1: begin
            state_q <= S_STX;
            shift_q <= sym(STX_B);
          end
          S_STX: begin
            if (data_valid) begin
              state_q <= S_PAYLOAD;
              shift_q <= sym(data_in);
`ifdef SB_DLE_STUFF_EN
              byte_q  <= data_in;
              dup_q   <= 1'b0;
`endif
            end else begin
              state_q <= S_IDLE;
              shift_q <= '1;
              err_q   <= 1'b1;
            end
          end
          S_PAYLOAD: begin
            if (stuff_now) begin
`ifdef SB_DLE_STUFF_EN
              shift_q <= sym(byte_q);
              dup_q   <= 1'b1;
`endif
            end else if (last_pay) begin
              state_q   <= S_CRC;
              crc_sym_q <= 1'b0;
              shift_q   <= '1;
            end else if (data_valid) begin
              shift_q <= sym(data_in);
              rem_q   <= rem_q - 4'd1;
`ifdef SB_DLE_STUFF_EN
              byte_q  <= data_in;
              dup_q   <= 1'b0;
`endif
            end else begin
              state_q <= S_IDLE;
              shift_q <= '1;
              err_q   <= 1'b1;
            end
          end
          S_CRC: begin
            if (crc_sym_q) begin
              state_q <= S_DLE2;
              shift_q <= sym(DLE_B);
            end else begin
              crc_sym_q <= 1'b1;
            end
          end
          S_DLE2: begin
            state_q <= S_ETX;
            shift_q <= sym(ETX_B);
          end
          S_ETX: begin
            state_q <= S_IDLE;
            shift_q <= '1;
            done_q  <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            shift_q <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sb_tx_framer.sv
// Bench for sb_tx_framer: per-cycle expected line/flag vectors are queued when a
// frame is launched and popped on every falling edge.
module tb_sb_tx_framer;

  logic       sb_clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       parity = 1'b0;
  logic       data_ready, crc_en, crc_active, trans_ser, sb_tx, busy, done, err;
  logic [2:0] dbg_state;
  logic [3:0] dbg_bit_cnt;

  sb_tx_framer dut (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .parity      (parity),
    .crc_en      (crc_en),
    .crc_active  (crc_active),
    .trans_ser   (trans_ser),
    .sb_tx       (sb_tx),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state),
    .dbg_bit_cnt (dbg_bit_cnt)
  );

  // clock
  always #5 sb_clk = ~sb_clk;

  // Entry bits: [7] line bit, [6] line follows parity, [5] busy, [4] crc_en,
  // [3] crc_active, [2] data_ready, [1] done, [0] err.
  localparam logic [7:0] IDLE_E = 8'h80;
  localparam logic [7:0] ERR_E  = 8'h81;
  localparam logic [7:0] DONE_E = 8'h82;

  logic [7:0] exp_q[$];
  logic [7:0] bytes_a[16];
  int         idx;
  int         nvalid;
  bit         keep_start;
  int         chk_cnt, pass_cnt, fail_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [7:0] d, input logic crc, input logic ce,
                          input logic rdy);
    logic [9:0] s;
    s = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++)
      exp_q.push_back({s[b], crc, 1'b1, ce, crc, (b == 9) ? rdy : 1'b0, 2'b00});
  endtask

  task automatic push_frame(input int n);
    push_sym(8'hFE, 1'b0, 1'b0, 1'b0);
    push_sym(8'h05, 1'b0, 1'b0, 1'b1);
    if (nvalid == 0) begin
      exp_q.push_back(ERR_E);
      return;
    end
    for (int i = 0; i < n; i++) begin
`ifdef SB_DLE_STUFF_EN
      if (bytes_a[i] == 8'hFE) push_sym(bytes_a[i], 1'b0, 1'b1, 1'b0);
`endif
      if (i == n - 1) begin
        push_sym(bytes_a[i], 1'b0, 1'b1, 1'b0);
      end else begin
        push_sym(bytes_a[i], 1'b0, 1'b1, 1'b1);
        if (i + 1 >= nvalid) begin
          exp_q.push_back(ERR_E);
          return;
        end
      end
    end
    push_sym(8'h00, 1'b1, 1'b1, 1'b0);
    push_sym(8'h00, 1'b1, 1'b1, 1'b0);
    push_sym(8'hFE, 1'b0, 1'b0, 1'b0);
    push_sym(8'h40, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(DONE_E);
  endtask

  // Called just after a rising edge: request a frame at the coming edge.
  task automatic chain(input int n, input int nv);
    idx        = 0;
    nvalid     = nv;
    data_in    = bytes_a[0];
    data_valid = (nv > 0);
    start      = 1'b1;
    len        = 4'(n);
    push_frame(n);
  endtask

  task automatic launch(input int n, input int nv);
    exp_q.push_back(IDLE_E);
    chain(n, nv);
  endtask

  task automatic step();
    logic [7:0] e;
    logic       exp_tx;
    logic       hs;
    parity = 1'($urandom_range(0, 1));
    @(negedge sb_clk);
    e      = exp_q.pop_front();
    exp_tx = e[6] ? parity : e[7];
    chk("line_flags", 32'({sb_tx, busy, crc_en, crc_active, data_ready, done, err}),
        32'({exp_tx, e[5:0]}));
    chk("trans_ser", 32'(trans_ser), 32'((e[4] && !e[3]) ? exp_tx : 1'b0));
    hs = data_ready && data_valid;
    @(posedge sb_clk);
    #1;
    if (hs) idx++;
    if (!keep_start) start = 1'b0;
    data_in    = (idx < 16) ? bytes_a[idx] : 8'h00;
    data_valid = (idx < nvalid);
  endtask

  task automatic run_until(input int remain);
    int budget;
    budget = 3000;
    while (exp_q.size() > remain && budget > 0) begin
      step();
      budget--;
    end
    chk("queue_drain", 32'(exp_q.size()), 32'(remain));
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++)
      bytes_a[i] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
  endtask

  initial begin
    int tgt;
    int n;
    chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
    keep_start = 1'b0;
    idx = 0; nvalid = 0;
    foreach (bytes_a[i]) bytes_a[i] = 8'h00;

    // reset state
    repeat (2) @(posedge sb_clk);
    @(negedge sb_clk);
    chk("reset_outputs",
        32'({sb_tx, busy, done, err, data_ready, crc_en, crc_active, trans_ser}),
        32'(8'b1000_0000));
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_bit_cnt", 32'(dbg_bit_cnt), 32'd0);

    // release, then a start on the very first edge: len=1, 0x3C
    @(posedge sb_clk); #1;
    rst = 1'b1;
    bytes_a[0] = 8'h3C;
    launch(1, 1);
    run_until(0);

    // len=3 followed back-to-back by len=2 started in the done cycle
    bytes_a[0] = 8'h01; bytes_a[1] = 8'h02; bytes_a[2] = 8'h03;
    launch(3, 3);
    run_until(1);
    bytes_a[0] = 8'hAA; bytes_a[1] = 8'h55;
    chain(2, 2);
    run_until(0);

    // start with len=0 is ignored
    keep_start = 1'b1;
    start = 1'b1;
    len = 4'd0;
    repeat (3) exp_q.push_back(IDLE_E);
    run_until(0);
    keep_start = 1'b0;
    start = 1'b0;
    chk("len0_state", 32'(dbg_state), 32'd0);

    // underrun at the second data_ready
    bytes_a[0] = 8'h11; bytes_a[1] = 8'h22;
    launch(2, 1);
    run_until(0);
    exp_q.push_back(IDLE_E);
    run_until(0);

    // underrun at the STX data_ready
    bytes_a[0] = 8'h77;
    launch(1, 0);
    run_until(0);

    // start held high mid-frame has no effect
    fill_rand(4);
    launch(4, 4);
    tgt = exp_q.size() - 25;
    run_until(tgt);
    keep_start = 1'b1;
    start = 1'b1;
    len = 4'd2;
    run_until(tgt - 20);
    keep_start = 1'b0;
    start = 1'b0;
    run_until(0);

    // reset in cycle 35 of a frame
    bytes_a[0] = 8'h5A; bytes_a[1] = 8'hC3; bytes_a[2] = 8'h0F;
    launch(3, 3);
    run_until(exp_q.size() - 35);
    #2 rst = 1'b0;
    #1;
    chk("midreset_outputs",
        32'({sb_tx, busy, done, err, data_ready, crc_en, crc_active, trans_ser}),
        32'(8'b1000_0000));
    chk("midreset_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    @(posedge sb_clk); #1;
    rst = 1'b1;
    bytes_a[0] = 8'h96; bytes_a[1] = 8'h69;
    launch(2, 2);
    run_until(0);

    // 0xFE payload: doubled only in the stuffing build
    bytes_a[0] = 8'hFE;
    launch(1, 1);
    run_until(0);
    bytes_a[0] = 8'hFE; bytes_a[1] = 8'h01; bytes_a[2] = 8'hFE;
    launch(3, 3);
    run_until(0);

    // random frames
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 15);
      fill_rand(n);
      launch(n, n);
      run_until(0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sb_tx_framer.md
SB_TX_FRAMER -- requirements
Module: sb_tx_framer

Interface
REQ-001 SHALL have ports: sb_clk  in  1  sideband bit clock, one line bit per cycle.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  frame request, sampled in IDLE only.
REQ-004 SHALL have ports: len  in  4  payload byte count, 1..15; 0 means no frame.
REQ-005 SHALL have ports: data_in  in  8  payload byte.
REQ-006 SHALL have ports: data_valid  in  1 / data_ready  out  1  payload byte handshake.
REQ-007 SHALL have ports: parity  in  1  serial CRC symbol bits from the CRC-16 generator.
REQ-008 SHALL have ports: crc_en  out  1 / crc_active  out  1 / trans_ser  out  1  CRC-16 generator controls.
REQ-009 SHALL have ports: sb_tx  out  1  serial line; busy  out  1; done  out  1; err  out  1.

Function
REQ-010 Every symbol SHALL be 10 bits: bit0 = start (0), bits1..8 = data LSB first, bit9 = stop (1).
REQ-011 Frame order SHALL be DLE(0xFE), STX(0x05), len payload symbols, 2 CRC symbols, DLE(0xFE), ETX(0x40).
REQ-012 FSM states SHALL be IDLE, DLE1, STX, PAYLOAD, CRC, DLE2, ETX, with one 4-bit bit counter (0..9) shared across states.
REQ-013 In IDLE, start=1 with len!=0 SHALL load len and put bit0 of DLE1 on sb_tx in the next cycle.
REQ-014 In IDLE, start with len=0 SHALL be ignored.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 Each symbol-to-symbol state advance SHALL occur only on bit9.
REQ-017 data_ready SHALL be 1 only in the bit9 cycle of STX and of every payload symbol except the last.
REQ-018 A byte SHALL be accepted when data_ready and data_valid are both 1, and its bit0 SHALL follow in the next cycle.
REQ-019 Underrun (data_ready=1, data_valid=0) SHALL abort: next cycle sb_tx=1, crc_en=0, err=1 for one cycle, state IDLE, done not asserted.
REQ-020 crc_en SHALL be 1 continuously from bit0 of the first payload symbol through bit9 of the second CRC symbol, and 0 otherwise.
REQ-021 trans_ser SHALL equal the current payload line bit during payload symbols, and 0 otherwise.
REQ-022 crc_active SHALL be 1 for exactly the 20 cycles of the two CRC symbols.
REQ-023 During those 20 cycles sb_tx SHALL equal parity; all other symbols SHALL be driven from the internal shift register.
REQ-024 busy SHALL be 1 from the first DLE1 bit through the ETX stop bit.
REQ-025 done SHALL pulse for 1 cycle in the cycle after the ETX stop bit, with the FSM in IDLE.
REQ-026 A new start accepted in that done cycle SHALL begin the next frame's DLE1 immediately, with no extra idle bit.
REQ-027 Idle line level SHALL be sb_tx=1.
REQ-028 Frame length without stuffing SHALL be (6+len)*10 cycles.

Reset
REQ-029 On rst=0, outputs SHALL be: sb_tx=1; busy, done, err, data_ready, crc_en, crc_active, trans_ser all 0; FSM IDLE; bit counter 0.
REQ-030 A reset mid-frame SHALL truncate the frame immediately with no completion pulse.
REQ-031 After release, the first start SHALL be honoured on the first clock edge.

Configuration
REQ-032 With SB_DLE_STUFF_EN defined, each accepted payload byte equal to 0xFE SHALL be sent twice back-to-back.
REQ-033 Under SB_DLE_STUFF_EN, data_ready SHALL stay 0 at the end of the first copy, and both copies SHALL count as CRC input (crc_en stays 1).
REQ-034 Under SB_DLE_STUFF_EN, len SHALL count accepted bytes, not transmitted symbols.
REQ-035 Without SB_DLE_STUFF_EN, 0xFE payload bytes SHALL be sent once and frame length SHALL always be (6+len)*10.

Verification
REQ-036 Reset, then start with len=1 and data 0x3C held valid -> sb_tx begins 0,0,1,1,1,1,1,1,1,1 (DLE) then 0,1,0,1,0,0,0,0,0,1 (STX); busy=1 for 70 cycles; done pulses once.
REQ-037 len=3, bytes 0x01,0x02,0x03 -> data_ready pulses exactly 3 times, 10 cycles apart; crc_en high 50 cycles contiguous; crc_active high 20 cycles; sb_tx tracks parity in that window.
REQ-038 len=2, data_valid=0 at the second data_ready -> err pulses 1 cycle, sb_tx=1, crc_en=0, no done, busy=0 next cycle.
REQ-039 start with len=0, and start asserted mid-frame -> no state change, sb_tx stays 1 / the frame is unaffected.
REQ-040 rst=0 at cycle 35 of a frame -> sb_tx=1 and all flags 0 in the same cycle; a new start after release produces a full correct frame.
REQ-041 With SB_DLE_STUFF_EN, len=1 and data 0xFE -> two identical 0xFE payload symbols, crc_en high 40 cycles, total 80 cycles; without the macro, 70 cycles.
